// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types and constants.
// Imported by the arbiter, its picker and the port interface.
package mem_arbiter_pkg;

  typedef enum logic {
    LAST0,
    LAST1
  } arb_last_t;

  localparam int PORT_INSTR = 0;
  localparam int PORT_DATA  = 1;

  // Map a one-hot grant to the port it names; hold on no grant.
  function automatic arb_last_t next_last(
    input logic [1:0] gnt,
    input arb_last_t  cur
  );
    arb_last_t r;
    r = cur;
    if (gnt[PORT_INSTR]) r = LAST0;
    else if (gnt[PORT_DATA]) r = LAST1;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Two requester ports plus the single-port memory bus.
// master = requesters and memory, slave = arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wd0;
  logic [DATA_W-1:0] wd1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd;
  logic              m_we;
  logic [DATA_W-1:0] m_rd;

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wd0, wd1,
    output m_rd,
    input  gnt0, gnt1,
    input  rvalid0, rvalid1, rd0, rd1,
    input  m_addr, m_wd, m_we
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wd0, wd1,
    input  m_rd,
    output gnt0, gnt1,
    output rvalid0, rvalid1, rd0, rd1,
    output m_addr, m_wd, m_we
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// Grants the port other than last when both request.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  arb_last_t  last,
  output logic [1:0] gnt
);

  // One-hot grant; favour the port not granted most recently.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b11:   gnt = (last == LAST0) ? 2'b10 : 2'b01;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory
// between instruction-fetch (port 0) and data (port 1).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] contention
);

  arb_last_t         r_last;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_rd0;
  logic              w_rd1;
  logic              w_both;

  assign w_req[PORT_INSTR] = bus.req0 & ~rst;
  assign w_req[PORT_DATA]  = bus.req1 & ~rst;
  assign w_both = bus.req0 & bus.req1;

  rr_pick2 u_pick (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign bus.gnt0 = w_gnt[PORT_INSTR];
  assign bus.gnt1 = w_gnt[PORT_DATA];

  assign w_rd0 = w_gnt[PORT_INSTR] & ~bus.we0;
  assign w_rd1 = w_gnt[PORT_DATA] & ~bus.we1;

  assign bus.m_addr = w_gnt[PORT_DATA]
                    ? bus.addr1 : bus.addr0;
  assign bus.m_wd   = w_gnt[PORT_DATA]
                    ? bus.wd1 : bus.wd0;
  assign bus.m_we   = (w_gnt[PORT_INSTR] & bus.we0)
                    | (w_gnt[PORT_DATA] & bus.we1);

  // Remember the most recently granted port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_last <= LAST1;
    else     r_last <= next_last(w_gnt, r_last);
  end

  // Capture read data at the grant edge; pulse rvalid once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rd0     <= '0;
      r_rd1     <= '0;
    end else begin
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0) r_rd0 <= bus.m_rd;
      if (w_rd1) r_rd1 <= bus.m_rd;
    end
  end

  // Count contended cycles, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (w_both && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rd0     = r_rd0;
  assign bus.rd1     = r_rd1;
  assign contention  = r_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small memory model.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0] g;
    logic       we;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] contention;
  bit         init_done = 1'b0;
  int         n_chk = 0;
  int         n_err = 0;

  exp_t        gq[$];
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  logic [31:0] mem[256];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .contention (contention)
  );

  always #5 clk = ~clk;

  assign bus.m_rd = mem[bus.m_addr[9:2]];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= {24'hA5A5A5, 8'(i)};
      init_done <= 1'b1;
    end else if (bus.m_we) begin
      mem[bus.m_addr[9:2]] <= bus.m_wd;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (gq.size() > 0) begin
      e = gq.pop_front();
      chk("gnt", {30'd0, bus.gnt1, bus.gnt0}, {30'd0, e.g});
      chk("m_we", {31'd0, bus.m_we}, {31'd0, e.we});
    end else begin
      chk("idle_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      chk("idle_m_we", {31'd0, bus.m_we}, 32'd0);
    end
    if (bus.rvalid0) begin
      if (rq0.size() > 0) chk("rd0", bus.rd0, rq0.pop_front());
      else chk("rvalid0_spurious", {31'd0, bus.rvalid0}, 32'd0);
    end
    if (bus.rvalid1) begin
      if (rq1.size() > 0) chk("rd1", bus.rd1, rq1.pop_front());
      else chk("rvalid1_spurious", {31'd0, bus.rvalid1}, 32'd0);
    end
  end

  task automatic step(input logic r0, input logic w0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic [1:0] eg, input logic ewe);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wd0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wd1 = d1;
    gq.push_back(exp_t'{g: eg, we: ewe});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = '0; bus.wd0 = '0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = '0; bus.wd1 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk("rst_m_we", {31'd0, bus.m_we}, 32'd0);
    chk("rst_cnt", {28'd0, contention}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    chk("rst_rd0", bus.rd0, 32'd0);
    chk("rst_rd1", bus.rd1, 32'd0);
    rst = 1'b0;

    // First contention after reset goes to port 0.
    rq0.push_back(32'hA5A5A500);
    step(1, 0, 32'h00, 0, 1, 0, 32'h04, 0, 2'b01, 1'b0);
    rq1.push_back(32'hA5A5A501);
    step(0, 0, 32'h00, 0, 1, 0, 32'h04, 0, 2'b10, 1'b0);
    idle();
    chk("cnt_first", {28'd0, contention}, 32'd1);

    // Write then read-after-write on port 1.
    do_reset();
    step(0, 0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 2'b10, 1'b1);
    rq1.push_back(32'hDEADBEEF);
    step(0, 0, 0, 0, 1, 0, 32'h40, 0, 2'b10, 1'b0);
    idle();

    // Continuous contention alternates 0,1,0,1,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        rq0.push_back(32'hA5A5A502);
        step(1, 0, 32'h08, 0, 1, 0, 32'h0C, 0, 2'b01, 1'b0);
      end else begin
        rq1.push_back(32'hA5A5A503);
        step(1, 0, 32'h08, 0, 1, 0, 32'h0C, 0, 2'b10, 1'b0);
      end
    end
    idle();
    chk("cnt_six", {28'd0, contention}, 32'd6);

    // Lone requester gets every cycle; then port 0 wins.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rq1.push_back(32'hA5A5A504);
      step(0, 0, 0, 0, 1, 0, 32'h10, 0, 2'b10, 1'b0);
    end
    rq0.push_back(32'hA5A5A505);
    step(1, 0, 32'h14, 0, 1, 0, 32'h10, 0, 2'b01, 1'b0);
    rq1.push_back(32'hA5A5A504);
    step(0, 0, 0, 0, 1, 0, 32'h10, 0, 2'b10, 1'b0);
    idle();
    chk("cnt_single", {28'd0, contention}, 32'd1);

    // Counter saturates at 15 with CNT_W = 4.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 32'h80, i, 1, 1, 32'h84, i,
           (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
      if (i == 13) chk("cnt_14", {28'd0, contention}, 32'd14);
    end
    chk("cnt_sat", {28'd0, contention}, 32'd15);
    idle();
    chk("cnt_hold", {28'd0, contention}, 32'd15);

    // Reset lands between a read grant and its return.
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h20;
    gq.push_back(exp_t'{g: 2'b01, we: 1'b0});
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rvalid0", {31'd0, bus.rvalid0}, 32'd0);
    chk("midrst_rd0", bus.rd0, 32'd0);
    chk("midrst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    bus.req0 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    idle();
    chk("midrst_rd0_after", bus.rd0, 32'd0);

    chk("gq_drained", gq.size(), 32'd0);
    chk("rq0_drained", rq0.size(), 32'd0);
    chk("rq1_drained", rq1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
